row_weight_loader: RTL

//   Write-side sequencer for the per-row weight storage that feeds the systolic array.

---
 rtl/row_weight_loader_if.sv | 28 ++
 rtl/row_weight_loader.sv | 129 ++++++++++++
 2 files changed

// File: rtl/row_weight_loader_if.sv
// Handshake and storage-write bundle for the row weight loader.
// The master side feeds weight elements and control; the slave side is the loader.
interface row_weight_loader_if #(
  parameter int SYSTOLIC_SIZE = 8,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
);
  logic                                  start;
  logic                                  abort;
  logic                                  in_valid;
  logic [WEIGHT_WIDTH-1:0]               in_data;
  logic                                  in_ready;
  logic                                  wr_en;
  logic [ADDR_WIDTH-1:0]                 wr_addr;
  logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0] wr_data;
  logic                                  busy;
  logic                                  done;

  modport master (
    output start, abort, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    input  start, abort, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/row_weight_loader.sv
// Write-side sequencer for the per-row weight storage of the systolic array.
// Packs SYSTOLIC_SIZE streamed elements into one row word and writes rows
// 0..SYSTOLIC_SIZE-1 in order, then pulses done once the tile is resident.
module row_weight_loader #(
  parameter int SYSTOLIC_SIZE = 8,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  row_weight_loader_if.slave bus
);

  localparam int                    ROW_W = SYSTOLIC_SIZE * WEIGHT_WIDTH;
  // Counters compare against the last index, so non-power-of-two sizes work.
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] col_cnt_q;
  logic [ADDR_WIDTH-1:0] row_cnt_q;
  logic [ROW_W-1:0]      pack_q;
  logic [ROW_W-1:0]      pack_d;
  logic                  in_ready_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [ROW_W-1:0]      wr_data_q;
  logic                  busy_q;
  logic                  done_q;

  // Pack word as it would look with the current element merged in at col_cnt.
  // NOTE: pack_d is assigned its default first so every path drives it and no latch is inferred.
  always_comb begin
    pack_d = pack_q;
    pack_d[int'(col_cnt_q)*WEIGHT_WIDTH +: WEIGHT_WIDTH] = bus.in_data;
  end

  // Tile sequencer: state, counters, pack register and all registered outputs.
  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_cnt_q  <= '0;
      row_cnt_q  <= '0;
      pack_q     <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // Strobes default low; wr_addr/wr_data hold their last values.
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      if (bus.abort) begin
        // Abort beats everything, including a beat or pending write this cycle.
        state_q    <= IDLE;
        col_cnt_q  <= '0;
        row_cnt_q  <= '0;
        pack_q     <= '0;
        in_ready_q <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (bus.start) begin
              state_q    <= LOAD;
              col_cnt_q  <= '0;
              row_cnt_q  <= '0;
              pack_q     <= '0;
              in_ready_q <= 1'b1;
              busy_q     <= 1'b1;
            end
          end
          LOAD: begin
            if (bus.in_valid) begin
              if (col_cnt_q == LAST) begin
                // Row complete: the write port gets a private copy, so packing
                // the next row cannot disturb wr_data.
                wr_en_q   <= 1'b1;
                wr_addr_q <= row_cnt_q;
                wr_data_q <= pack_d;
                col_cnt_q <= '0;
                pack_q    <= '0;
                if (row_cnt_q == LAST) begin
                  state_q    <= FLUSH;
                  row_cnt_q  <= '0;
                  in_ready_q <= 1'b0;
                end else begin
                  row_cnt_q <= row_cnt_q + ADDR_WIDTH'(1);
                end
              end else begin
                pack_q    <= pack_d;
                col_cnt_q <= col_cnt_q + ADDR_WIDTH'(1);
              end
            end
          end
          FLUSH: begin
            // Final row write is on the port this cycle; report next cycle.
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
